lr_button_conditioner: RTL and testbench

Conditions the two raw push-buttons that step the speed-select FSM. Each button is synchronised and debounced, then an arbiter emits a single-cycle LR command pulse (10 = left, 01 = right). Holding a button auto-repeats its pulse. The block's registered LR output connects directly to the LR input of the speed-select FSM, which expects at most one pulse per press and never the value 11.

---
 rtl/vdfsm_pkg.sv | 16 +
 rtl/btn_debounce.sv | 41 ++++
 rtl/lr_button_conditioner.sv | 110 +++++++++++
 tb/tb_lr_button_conditioner.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/vdfsm_pkg.sv
// Definitions shared between the button conditioner and the speed-select FSM:
// LR command codes and the arbiter state encoding.
package vdfsm_pkg;

  localparam logic [1:0] LR_NONE  = 2'b00;
  localparam logic [1:0] LR_LEFT  = 2'b10;
  localparam logic [1:0] LR_RIGHT = 2'b01;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD_L = 2'd1,
    HOLD_R = 2'd2,
    BLOCK  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser followed by a counting debouncer: the output level
// toggles only after DEBOUNCE_CYCLES consecutive cycles of disagreement.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned CNT_W           = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_btn,
  output logic o_db
);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_db;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_db    <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      if (r_sync2 == r_db) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        // this increment would reach DEBOUNCE_CYCLES: accept the new level
        r_db  <= ~r_db;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_db = r_db;

endmodule

// File: rtl/lr_button_conditioner.sv
// Debounces the left/right push-buttons and arbitrates them into single-cycle
// LR command pulses with hold-to-auto-repeat; simultaneous presses are blocked.
module lr_button_conditioner
  import vdfsm_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned HOLD_CYCLES     = 1000,
  parameter int unsigned REPEAT_CYCLES   = 250,
  parameter int unsigned CNT_W           = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_l,
  input  logic       btn_r,
  output logic [1:0] LR,
  output logic       l_db,
  output logic       r_db
);

  logic             w_l_db;
  logic             w_r_db;
  arb_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_lr;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_db_l (
    .i_clk  (clk),
    .i_rst_n(reset),
    .i_btn  (btn_l),
    .o_db   (w_l_db)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_db_r (
    .i_clk  (clk),
    .i_rst_n(reset),
    .i_btn  (btn_r),
    .o_db   (w_r_db)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_lr    <= LR_NONE;
    end else begin
      r_lr <= LR_NONE;
      unique case (r_state)
        IDLE: begin
          if (w_l_db && w_r_db) begin
            r_state <= BLOCK;
          end else if (w_l_db) begin
            r_state <= HOLD_L;
            r_lr    <= LR_LEFT;
            r_cnt   <= CNT_W'(HOLD_CYCLES);
          end else if (w_r_db) begin
            r_state <= HOLD_R;
            r_lr    <= LR_RIGHT;
            r_cnt   <= CNT_W'(HOLD_CYCLES);
          end
        end
        HOLD_L: begin
          // cross-press and release are checked before any repeat can fire
          if (w_r_db) begin
            r_state <= BLOCK;
          end else if (!w_l_db) begin
            r_state <= IDLE;
          end else if (r_cnt == CNT_W'(1)) begin
            if (REPEAT_CYCLES != 0) begin
              r_lr  <= LR_LEFT;
              r_cnt <= CNT_W'(REPEAT_CYCLES);
            end
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        HOLD_R: begin
          if (w_l_db) begin
            r_state <= BLOCK;
          end else if (!w_r_db) begin
            r_state <= IDLE;
          end else if (r_cnt == CNT_W'(1)) begin
            if (REPEAT_CYCLES != 0) begin
              r_lr  <= LR_RIGHT;
              r_cnt <= CNT_W'(REPEAT_CYCLES);
            end
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        BLOCK: begin
          if (!w_l_db && !w_r_db) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign LR   = r_lr;
  assign l_db = w_l_db;
  assign r_db = w_r_db;

endmodule

// File: tb/tb_lr_button_conditioner.sv
// Directed bench for lr_button_conditioner with DEBOUNCE=4, HOLD=20, REPEAT=8.
module tb_lr_button_conditioner;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_l = 1'b0;
  logic       btn_r = 1'b0;
  logic [1:0] LR;
  logic       l_db;
  logic       r_db;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  lr_button_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (20),
    .REPEAT_CYCLES  (8),
    .CNT_W          (16)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .btn_l(btn_l),
    .btn_r(btn_r),
    .LR   (LR),
    .l_db (l_db),
    .r_db (r_db)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // advance one clock edge; inputs change and outputs are sampled 1ns later
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_lr(input string tag, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      tick();
      check(tag, 32'(LR), 32'h0);
    end
  endtask

  initial begin
    // 1. reset with both buttons high, then a clean left press
    btn_l = 1'b1;
    btn_r = 1'b1;
    reset = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      tick();
      check("rst_lr", 32'(LR), 32'h0);
      check("rst_ldb", 32'(l_db), 32'h0);
      check("rst_rdb", 32'(r_db), 32'h0);
    end
    reset = 1'b1;
    btn_l = 1'b0;
    btn_r = 1'b0;
    idle_lr("post_rst_lr", 10);
    btn_l = 1'b1;
    for (int unsigned k = 1; k <= 10; k++) begin
      tick();
      check("s1_ldb", 32'(l_db), (k >= 6) ? 32'h1 : 32'h0);
      check("s1_lr", 32'(LR), (k == 7) ? 32'h2 : 32'h0);
    end
    btn_l = 1'b0;
    idle_lr("s1_release_lr", 20);
    check("s1_ldb_fall", 32'(l_db), 32'h0);

    // 2. bouncing right button, then settles high
    for (int unsigned p = 0; p < 7; p++) begin
      btn_r = 1'b1;
      idle_lr("s2_bounce_lr", 2);
      check("s2_bounce_rdb", 32'(r_db), 32'h0);
      btn_r = 1'b0;
      idle_lr("s2_bounce_lr", 2);
    end
    btn_r = 1'b1;
    for (int unsigned k = 1; k <= 10; k++) begin
      tick();
      check("s2_rdb", 32'(r_db), (k >= 6) ? 32'h1 : 32'h0);
      check("s2_lr", 32'(LR), (k == 7) ? 32'h1 : 32'h0);
    end
    btn_r = 1'b0;
    idle_lr("s2_release_lr", 20);

    // 3. auto-repeat while holding left: t0, t0+20, then every 8
    btn_l = 1'b1;
    for (int unsigned k = 1; k <= 7; k++) begin
      tick();
      check("s3_first_lr", 32'(LR), (k == 7) ? 32'h2 : 32'h0);
    end
    for (int unsigned k = 1; k <= 60; k++) begin
      tick();
      check("s3_rep_lr", 32'(LR),
            (k == 20 || (k > 20 && (k - 20) % 8 == 0)) ? 32'h2 : 32'h0);
    end
    btn_l = 1'b0;
    idle_lr("s3_release_lr", 20);
    check("s3_ldb_fall", 32'(l_db), 32'h0);

    // 4. simultaneous press goes straight to BLOCK
    btn_l = 1'b1;
    btn_r = 1'b1;
    idle_lr("s4_both_lr", 40);
    check("s4_ldb", 32'(l_db), 32'h1);
    check("s4_rdb", 32'(r_db), 32'h1);
    btn_r = 1'b0;
    idle_lr("s4_lonly_lr", 30);
    btn_l = 1'b0;
    idle_lr("s4_none_lr", 20);
    btn_r = 1'b1;
    for (int unsigned k = 1; k <= 10; k++) begin
      tick();
      check("s4_fresh_lr", 32'(LR), (k == 7) ? 32'h1 : 32'h0);
    end
    btn_r = 1'b0;
    idle_lr("s4_release_lr", 20);

    // 5. right pressed during left hold: no further pulses of either kind
    btn_l = 1'b1;
    for (int unsigned k = 1; k <= 7; k++) begin
      tick();
      check("s5_first_lr", 32'(LR), (k == 7) ? 32'h2 : 32'h0);
    end
    idle_lr("s5_pre_lr", 5);
    btn_r = 1'b1;
    idle_lr("s5_cross_lr", 40);
    btn_l = 1'b0;
    btn_r = 1'b0;
    idle_lr("s5_release_lr", 20);

    // 6. reset pulse mid-hold; held button re-presses after reset
    btn_l = 1'b1;
    for (int unsigned k = 1; k <= 7; k++) begin
      tick();
      check("s6_first_lr", 32'(LR), (k == 7) ? 32'h2 : 32'h0);
    end
    idle_lr("s6_hold_lr", 14);
    reset = 1'b0;
    tick();
    check("s6_rst_lr", 32'(LR), 32'h0);
    check("s6_rst_ldb", 32'(l_db), 32'h0);
    reset = 1'b1;
    for (int unsigned k = 1; k <= 10; k++) begin
      tick();
      check("s6_again_lr", 32'(LR), (k == 7) ? 32'h2 : 32'h0);
    end
    btn_l = 1'b0;
    idle_lr("s6_release_lr", 20);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
